// File: rtl/t03_load_store_unit.sv
// t03_load_store_unit: data-memory access unit for the team_03 RV32I core.
// Turns a load/store from execute into one req/ack transaction on the data
// bus, freezes the core while the transaction is in flight, and returns
// aligned, sign/zero-extended load data for the register-file writeback path.
//
// Bus handshake: bus_req rises at the edge that leaves IDLE and holds, with
// bus_we/bus_addr/bus_sel/bus_wdata stable, until the edge that samples
// bus_ack high (a single-cycle completion pulse, with bus_rdata valid in
// that same cycle) or until the wait counter expires. bus_ack is ignored
// outside WAIT.
//
// Debug visibility: the FSM state lives in state_q (typed as state_t), so a
// checker can bind to it directly.
module t03_load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] data_out,
  output logic        freeze,
  output logic        access_fault,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter value seen in the last permitted WAIT cycle; bus_req is then
  // high for exactly TIMEOUT cycles.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] data_out_q, data_out_d;
  logic        access_fault_q, access_fault_d;
  logic        bus_timeout_q, bus_timeout_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  offset_q, offset_d;
  logic [2:0]  funct3_q, funct3_d;

  logic        is_access;
  logic        illegal;
  logic [3:0]  sel_new;
  logic [31:0] wdata_new;
  logic [31:0] rdata_shifted;
  logic [31:0] load_val;

  // Classify the incoming instruction: any access at all, and whether it is illegal.
  always_comb begin
    is_access = mem_read | mem_write;
    illegal   = 1'b0;
    if (mem_read && mem_write) begin
      illegal = 1'b1;
    end
    if (mem_read && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)) begin
      illegal = 1'b1;
    end
    if (mem_write && !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010)) begin
      illegal = 1'b1;
    end
    // Halfword must be 2-byte aligned, word must be 4-byte aligned.
    if (funct3[1:0] == 2'b01 && addr[0]) begin
      illegal = 1'b1;
    end
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) begin
      illegal = 1'b1;
    end
  end

  // Byte enables and lane-replicated write data for a new access.
  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        sel_new   = 4'b0001 << addr[1:0];
        wdata_new = {4{store_data[7:0]}};
      end
      2'b01: begin
        sel_new   = 4'b0011 << {addr[1], 1'b0};
        wdata_new = {2{store_data[15:0]}};
      end
      default: begin
        sel_new   = 4'b1111;
        wdata_new = store_data;
      end
    endcase
  end

  // Align the returned word to the latched byte offset, then extend by latched funct3.
  always_comb begin
    rdata_shifted = bus_rdata >> {offset_q, 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_val = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_val = {24'h000000, rdata_shifted[7:0]};
      3'b101:  load_val = {16'h0000, rdata_shifted[15:0]};
      default: load_val = rdata_shifted;
    endcase
  end

  // Next-state and next-output logic for the IDLE/WAIT/DONE sequencer.
  always_comb begin
    state_d        = state_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_sel_d      = bus_sel_q;
    bus_wdata_d    = bus_wdata_q;
    data_out_d     = data_out_q;
    access_fault_d = access_fault_q;
    bus_timeout_d  = bus_timeout_q;
    cnt_d          = cnt_q;
    offset_d       = offset_q;
    funct3_d       = funct3_q;

    case (state_q)
      ST_IDLE: begin
        if (is_access) begin
          if (illegal) begin
            // Reject without touching the bus.
            state_d        = ST_DONE;
            access_fault_d = 1'b1;
            data_out_d     = 32'h0;
          end else begin
            state_d     = ST_WAIT;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_sel_d   = sel_new;
            bus_wdata_d = wdata_new;
            offset_d    = addr[1:0];
            funct3_d    = funct3;
            cnt_d       = 8'd0;
          end
        end
      end

      ST_WAIT: begin
        if (bus_ack) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            data_out_d = load_val;
          end
        end else if (cnt_q == LAST_CNT) begin
          state_d       = ST_DONE;
          bus_req_d     = 1'b0;
          bus_timeout_d = 1'b1;
          if (!bus_we_q) begin
            data_out_d = 32'h0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_DONE: begin
        // The finished instruction is still on the inputs here; never re-trigger.
        state_d        = ST_IDLE;
        access_fault_d = 1'b0;
        bus_timeout_d  = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // Register all FSM state and bus-facing outputs; asynchronous reset to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= 32'h0;
      bus_sel_q      <= 4'h0;
      bus_wdata_q    <= 32'h0;
      data_out_q     <= 32'h0;
      access_fault_q <= 1'b0;
      bus_timeout_q  <= 1'b0;
      cnt_q          <= 8'd0;
      offset_q       <= 2'b00;
      funct3_q       <= 3'b000;
    end else begin
      state_q        <= state_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_sel_q      <= bus_sel_d;
      bus_wdata_q    <= bus_wdata_d;
      data_out_q     <= data_out_d;
      access_fault_q <= access_fault_d;
      bus_timeout_q  <= bus_timeout_d;
      cnt_q          <= cnt_d;
      offset_q       <= offset_d;
      funct3_q       <= funct3_d;
    end
  end

  // Stall the core while an access is being accepted or is in flight.
  always_comb begin
    freeze = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: freeze = is_access;
        ST_WAIT: freeze = 1'b1;
        default: freeze = 1'b0;
      endcase
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_sel      = bus_sel_q;
  assign bus_wdata    = bus_wdata_q;
  assign data_out     = data_out_q;
  assign access_fault = access_fault_q;
  assign bus_timeout  = bus_timeout_q;

endmodule

// File: tb/tb_t03_load_store_unit.sv
// Bench for t03_load_store_unit: directed vector table, hand-written reset /
// late-ack / back-to-back sequences, and randomized accesses checked against
// a byte-level reference model.
module tb_t03_load_store_unit;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] data_out;
  logic        freeze;
  logic        access_fault;
  logic        bus_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_dout;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          ack_n;   // WAIT cycle in which ack is pulsed; 0 = never
  } vec_t;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic        fault;
    logic        tout;
  } exp_t;

  typedef struct {
    vec_t v;
    exp_t e;
  } rec_t;

  rec_t tbl[16];

  t03_load_store_unit #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_sel      (bus_sel),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .data_out     (data_out),
    .freeze       (freeze),
    .access_fault (access_fault),
    .bus_timeout  (bus_timeout)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rdata, input int ack_n,
                              input logic [3:0] sel, input logic [31:0] wdata,
                              input logic [31:0] dout, input logic fault, input logic tout);
    rec_t r;
    r.v.rd = rd; r.v.wr = wr; r.v.f3 = f3; r.v.addr = a; r.v.sd = sd;
    r.v.rdata = rdata; r.v.ack_n = ack_n;
    r.e.sel = sel; r.e.wdata = wdata; r.e.dout = dout; r.e.fault = fault; r.e.tout = tout;
    return r;
  endfunction

  // Reference model: access size, lane positions and extension from plain byte arithmetic.
  function automatic exp_t ref_model(input vec_t v, input logic [31:0] prev);
    exp_t   e;
    int     size;
    int     off;
    longint val;
    e = '{default: '0};
    case (v.f3[1:0])
      2'd0: size = 1;
      2'd1: size = 2;
      2'd2: size = 4;
      default: size = 0;
    endcase
    off = int'(v.addr[1:0]);
    e.fault = (v.rd && v.wr) ||
              (v.rd && (v.f3 == 3'd3 || v.f3 == 3'd6 || v.f3 == 3'd7)) ||
              (v.wr && v.f3 > 3'd2) || (size == 0) ||
              (size != 0 && (off % size) != 0);
    val = 0;
    if (size != 0) begin
      for (int i = 0; i < 4; i++) begin
        e.sel[i] = (i >= off) && (i < off + size);
        e.wdata[8*i +: 8] = v.sd[8*(i % size) +: 8];
      end
      for (int j = 0; j < size; j++) begin
        if (off + j < 4) val += longint'(v.rdata[8*(off+j) +: 8]) << (8*j);
      end
      if (!v.f3[2] && size < 4 && val >= (longint'(1) << (8*size-1)))
        val -= (longint'(1) << (8*size));
    end
    e.tout = !e.fault && !(v.ack_n >= 1 && v.ack_n <= TO);
    if (e.fault)      e.dout = 32'h0;
    else if (e.tout)  e.dout = v.rd ? 32'h0 : prev;
    else              e.dout = v.rd ? val[31:0] : prev;
    return e;
  endfunction

  // Drive one instruction at a negedge in IDLE, act as the bus, check DONE and the return to IDLE.
  task automatic run_access(input string tag, input vec_t v, input exp_t e);
    int k;
    int fr_cnt;
    int rq_cnt;
    int exp_fr;
    int exp_rq;
    bit done;
    if (e.fault)     begin exp_fr = 1;          exp_rq = 0;       end
    else if (e.tout) begin exp_fr = TO + 1;     exp_rq = TO;      end
    else             begin exp_fr = v.ack_n + 1; exp_rq = v.ack_n; end
    mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.addr;
    store_data = v.sd; bus_ack = 1'b0;
    #1;
    chk({tag, " freeze_idle"}, 32'(freeze), 32'd1);
    fr_cnt = 1; rq_cnt = 0; k = 0; done = 0;
    @(negedge clk);
    while (!done && k < 300) begin
      if (!freeze) begin
        done = 1;
      end else begin
        k++;
        fr_cnt++;
        if (bus_req) rq_cnt++;
        chk({tag, " bus_addr"}, bus_addr, {v.addr[31:2], 2'b00});
        chk({tag, " bus_we"}, 32'(bus_we), 32'(v.wr));
        chk({tag, " bus_sel"}, 32'(bus_sel), 32'(e.sel));
        if (v.wr) chk({tag, " bus_wdata"}, bus_wdata, e.wdata);
        bus_ack   = (k == v.ack_n);
        bus_rdata = bus_ack ? v.rdata : $urandom();
        @(negedge clk);
        bus_ack = 1'b0;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s done_wait: freeze still high after %0d cycles", tag, k);
    end
    chk({tag, " freeze_cycles"}, 32'(fr_cnt), 32'(exp_fr));
    chk({tag, " req_cycles"}, 32'(rq_cnt), 32'(exp_rq));
    chk({tag, " done_req"}, 32'(bus_req), 32'd0);
    chk({tag, " data_out"}, data_out, e.dout);
    chk({tag, " access_fault"}, 32'(access_fault), 32'(e.fault));
    chk({tag, " bus_timeout"}, 32'(bus_timeout), 32'(e.tout));
    // Instruction still held through DONE: next cycle is IDLE, nothing re-issued.
    @(negedge clk);
    chk({tag, " idle_req"}, 32'(bus_req), 32'd0);
    chk({tag, " idle_fault_clr"}, 32'(access_fault), 32'd0);
    chk({tag, " idle_tout_clr"}, 32'(bus_timeout), 32'd0);
    model_dout = e.dout;
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = 32'h0;
    store_data = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
  endtask

  initial begin
    vec_t v;
    exp_t e;

    // Directed vectors (TIMEOUT = 4); dout of stores carries the prior result.
    tbl[0]  = mk(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0);
    tbl[1]  = mk(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1, 4'h8, 32'h0, 32'hFFFFFF80, 0, 0);
    tbl[2]  = mk(1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 3, 4'h8, 32'h0, 32'h00000080, 0, 0);
    tbl[3]  = mk(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 1, 4'hC, 32'hABCDABCD, 32'h00000080, 0, 0);
    tbl[4]  = mk(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0, 1, 0);
    tbl[5]  = mk(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0, 1, 0);
    tbl[6]  = mk(1, 0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 4, 4'hC, 32'h0, 32'hFFFF8001, 0, 0);
    tbl[7]  = mk(1, 0, 3'b101, 32'h100, 32'h0, 32'h12348765, 1, 4'h3, 32'h0, 32'h00008765, 0, 0);
    tbl[8]  = mk(0, 1, 3'b000, 32'h301, 32'h123456A5, 32'h0, 2, 4'h2, 32'hA5A5A5A5, 32'h00008765, 0, 0);
    tbl[9]  = mk(1, 0, 3'b010, 32'h400, 32'h0, 32'h11111111, 0, 4'hF, 32'h0, 32'h0, 0, 1);
    tbl[10] = mk(1, 0, 3'b000, 32'h100, 32'h0, 32'h0000007F, 1, 4'h1, 32'h0, 32'h0000007F, 0, 0);
    tbl[11] = mk(0, 1, 3'b010, 32'h404, 32'hCAFEF00D, 32'h0, 5, 4'hF, 32'hCAFEF00D, 32'h0000007F, 0, 1);
    tbl[12] = mk(1, 0, 3'b011, 32'h0, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0, 1, 0);
    tbl[13] = mk(0, 1, 3'b100, 32'h0, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0, 1, 0);
    tbl[14] = mk(0, 1, 3'b001, 32'h201, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0, 1, 0);
    tbl[15] = mk(1, 0, 3'b110, 32'h0, 32'h0, 32'h0, 1, 4'h0, 32'h0, 32'h0, 1, 0);

    // Reset
    reset = 1'b1;
    idle_inputs();
    model_dout = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst bus_req", 32'(bus_req), 32'd0);
    chk("rst bus_we", 32'(bus_we), 32'd0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_sel", 32'(bus_sel), 32'd0);
    chk("rst bus_wdata", bus_wdata, 32'h0);
    chk("rst data_out", data_out, 32'h0);
    chk("rst access_fault", 32'(access_fault), 32'd0);
    chk("rst bus_timeout", 32'(bus_timeout), 32'd0);
    chk("rst freeze", 32'(freeze), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle freeze", 32'(freeze), 32'd0);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      run_access($sformatf("vec%0d", i), tbl[i].v, tbl[i].e);
    end
    idle_inputs();
    @(negedge clk);

    // Timeout followed by a late ack that must be ignored
    v = '{rd: 1'b1, wr: 1'b0, f3: 3'b010, addr: 32'h600, sd: 32'h0, rdata: 32'h12345678, ack_n: 0};
    e = ref_model(v, model_dout);
    run_access("late_ack", v, e);
    idle_inputs();
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("late_ack req", 32'(bus_req), 32'd0);
    chk("late_ack freeze", 32'(freeze), 32'd0);
    chk("late_ack data_out", data_out, 32'h0);
    @(negedge clk);
    chk("late_ack still_idle", 32'(bus_req), 32'd0);

    // Reset in the middle of WAIT
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
    @(negedge clk);
    chk("midrst req_before", 32'(bus_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst req", 32'(bus_req), 32'd0);
    chk("midrst freeze", 32'(freeze), 32'd0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("midrst ack_ignored_req", 32'(bus_req), 32'd0);
    chk("midrst ack_ignored_dout", data_out, 32'h0);
    model_dout = 32'h0;

    // Back-to-back SB then LB, each instruction held through its DONE
    v = '{rd: 1'b0, wr: 1'b1, f3: 3'b000, addr: 32'h10, sd: 32'h0000005A, rdata: 32'h0, ack_n: 1};
    e = ref_model(v, model_dout);
    run_access("b2b_sb", v, e);
    v = '{rd: 1'b1, wr: 1'b0, f3: 3'b000, addr: 32'h13, sd: 32'h0, rdata: 32'h85000000, ack_n: 2};
    e = ref_model(v, model_dout);
    chk("b2b_lb model", e.dout, 32'hFFFFFF85);
    run_access("b2b_lb", v, e);
    idle_inputs();
    @(negedge clk);

    // Randomized accesses against the reference model
    for (int i = 0; i < 40; i++) begin
      int pick;
      pick = $urandom_range(0, 9);
      v.rd    = (pick < 5) || (pick == 9);
      v.wr    = (pick >= 5);
      v.f3    = 3'($urandom_range(0, 7));
      v.addr  = $urandom();
      v.sd    = $urandom();
      v.rdata = $urandom();
      v.ack_n = $urandom_range(0, 5);
      e = ref_model(v, model_dout);
      run_access($sformatf("rnd%0d", i), v, e);
    end
    idle_inputs();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/t03_load_store_unit.md
# t03_load_store_unit

Data-memory access unit for the team_03 RV32I core. Sits between execute and writeback: takes the ALU-computed address, rs2 store data and funct3 from the current instruction. It runs a req/ack transaction on the data bus and freezes the core while the transaction is in flight. It returns aligned, sign/zero-extended load data as `data_out`, which feeds the register file's memory writeback path.

## Interface

Parameters:
- TIMEOUT, 255: max cycles waiting for `bus_ack` before aborting (1..255).

Ports:
- clk  input  1  core clock.
- reset  input  1  reset reset, asynchronous, active-high; clock clk.
- mem_read  input  1  current instruction is a load.
- mem_write  input  1  current instruction is a store.
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only).
- addr  input  32  byte address from ALU.
- store_data  input  32  rs2 value.
- bus_req  output  1  transaction request, held until ack.
- bus_we  output  1  1 = write.
- bus_addr  output  32  word-aligned address {addr[31:2],2'b00}.
- bus_sel  output  4  byte enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_rdata  input  32  read word, valid with `bus_ack`.
- bus_ack  input  1  one-cycle completion pulse.
- data_out  output  32  extended load result to register file.
- freeze  output  1  stall PC/pipeline; combinational.
- access_fault  output  1  misaligned/illegal access, valid in DONE.
- bus_timeout  output  1  ack timeout, valid in DONE.

## Operation

- FSM states: IDLE, WAIT, DONE.
- IDLE, no access (mem_read=mem_write=0): stay; freeze=0.
- IDLE, legal access: register bus_addr, bus_we=mem_write, bus_sel, bus_wdata, offset=addr[1:0], funct3, and set bus_req=1. Next state is WAIT. freeze=1 this cycle.
- IDLE, illegal access goes straight to DONE with no bus activity, access_fault=1 and data_out=0; freeze=1 this cycle. Illegal means any of:
  - mem_read and mem_write both high;
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010}.
- WAIT: freeze=1.
  - On bus_ack, latch the extracted load value (stores: data_out unchanged), drop bus_req at that edge, and go to DONE.
  - If the wait counter reaches TIMEOUT without ack, drop bus_req, set bus_timeout=1 and data_out=0 (loads), and go to DONE.
- DONE: freeze=0 for one cycle; the register file writes data_out at the edge ending DONE. DONE always returns to IDLE; the instruction still present during DONE never re-triggers.
- access_fault and bus_timeout are high only in DONE and clear on return to IDLE.
- Byte enables:
  - B: 0001<<offset.
  - H: 0011<<{offset[1],0}.
  - W: 1111.
- Write data:
  - SB: {4{store_data[7:0]}}.
  - SH: {2{store_data[15:0]}}.
  - SW: store_data.
- Load extract: shift bus_rdata right by 8*offset, take byte/half, then sign-extend (000/001) or zero-extend (100/101). W passes through.
- Wait counter is 8 bits, cleared on entry to WAIT.
- bus_ack is ignored outside WAIT.

## Timing

- Reset (async): state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0, data_out=0, access_fault=0, bus_timeout=0, counter=0; freeze=0.
- Reset mid-WAIT drops bus_req immediately; a later ack is ignored.
- Legal access with ack N cycles after bus_req rises (N≥1): freeze is high for N+1 cycles, then DONE; total N+2 cycles per instruction.
  - Zero-wait bus (ack in the first WAIT cycle) gives 3 cycles total.
- Illegal access: 2 cycles (IDLE + DONE), no bus_req.
- Timeout: bus_req stays high for exactly TIMEOUT cycles. DONE follows on the next cycle.
- bus_* outputs are registered and stable for the whole of WAIT.

## Test plan

- LW addr=0x100, store none, bus_rdata=0xDEADBEEF with ack after 2 cycles -> bus_addr=0x100, bus_sel=1111, bus_we=0, freeze high 3 cycles, data_out=0xDEADBEEF in DONE.
- LB / LBU at addr=0x103, bus_rdata=0x80123456 -> bus_sel=1000; data_out=0xFFFFFF80 (LB) / 0x00000080 (LBU).
- SH addr=0x202, store_data=0x0000ABCD -> bus_addr=0x200, bus_sel=1100, bus_we=1, bus_wdata=0xABCDABCD; data_out unchanged.
- LW addr=0x101 and mem_read=mem_write=1 cases -> no bus_req, DONE after 1 cycle, access_fault=1, data_out=0.
- TIMEOUT=4, LW with ack never asserted -> bus_req high exactly 4 cycles, then DONE with bus_timeout=1, data_out=0; a late ack is ignored.
- Assert reset during WAIT -> bus_req=0 and freeze=0 immediately; after release, a back-to-back SB then LB sequence completes normally with no spurious re-trigger in DONE.
